// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: multi-cycle instruction memory responder for the fetch stage.
// Accepts one fetch at a time and returns the word LATENCY cycles later with a one-cycle
// valid pulse. A taken branch can abort an in-flight fetch. A side load port fills program
// memory independently of the fetch state machine.
// Optional statistics counters are built when the macro IFR_STATS_EN is defined.
module inst_fetch_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        abort,
    output logic        ready,
    output logic        valid,
    output logic [31:0] inst,
    output logic        err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [15:0] fetch_count,
    output logic [15:0] abort_count
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_START = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [29:0] areg;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [29:0] rd_idx;
    logic        rd_oor;
    logic [31:0] rd_word;
    logic        unused_bits;

    // Byte-offset bits and load address bits beyond the memory depth carry no meaning here
    assign unused_bits = &{1'b0, addr[1:0], load_addr[1:0], load_addr[31:AW+2]};

    // Handshake outputs are pure state decodes so there is no input-to-output path
    assign ready = (state != WAIT);
    assign valid = (state == RESP);

    // Accept qualification and the word read at RESP entry; a WAIT exit reads the latched
    // address, a single-cycle fetch reads the address presented on the accept edge
    always_comb begin
        accept  = req && !abort && (state != WAIT);
        rd_idx  = (state == WAIT) ? areg : addr[31:2];
        rd_oor  = (rd_idx >= 30'(DEPTH_WORDS));
        rd_word = rd_oor ? 32'h0000_0000 : mem[rd_idx[AW-1:0]];
    end

    // Fetch state machine with registered response data; abort wins over every other action
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            areg  <= 30'd0;
            inst  <= 32'h0000_0000;
            err   <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == 3'd0) begin
                        state <= RESP;
                        inst  <= rd_word;
                        err   <= rd_oor;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        areg <= addr[31:2];
                        if (LATENCY == 1) begin
                            state <= RESP;
                            inst  <= rd_word;
                            err   <= rd_oor;
                        end else begin
                            cnt   <= CNT_START;
                            state <= WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Program memory load; the read above sees the pre-write contents on a colliding edge
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

`ifdef IFR_STATS_EN
    logic [15:0] fcnt;
    logic [15:0] acnt;

    // Completed-fetch and aborted-fetch counters, free-running and wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= 16'd0;
            acnt <= 16'd0;
        end else begin
            if (state == RESP) begin
                fcnt <= fcnt + 16'd1;
            end
            if ((state == WAIT) && abort) begin
                acnt <= acnt + 16'd1;
            end
        end
    end

    assign fetch_count = fcnt;
    assign abort_count = acnt;
`else
    assign fetch_count = 16'd0;
    assign abort_count = 16'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: drives three responders (LATENCY 1, 2 and 3) from one shared
// stimulus stream and compares every output each cycle against a transaction-level model.
module tb_inst_fetch_responder;
    localparam int DEPTH = 64;
    localparam int NI    = 3;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        abort;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [NI-1:0] readyV;
    logic [NI-1:0] validV;
    logic [NI-1:0] errV;
    logic [31:0]   instV [NI];
    logic [15:0]   fcV [NI];
    logic [15:0]   acV [NI];

    int checks;
    int errors;

    logic [31:0] memM [DEPTH];
    bit          busyM [NI];
    int          leftM [NI];
    bit          validM [NI];
    logic [31:0] instM [NI];
    bit          errM [NI];
    logic [29:0] pendM [NI];
    logic [15:0] fcM [NI];
    logic [15:0] acM [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        inst_fetch_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (g + 1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req        (req),
            .addr       (addr),
            .abort      (abort),
            .ready      (readyV[g]),
            .valid      (validV[g]),
            .inst       (instV[g]),
            .err        (errV[g]),
            .load_en    (load_en),
            .load_addr  (load_addr),
            .load_data  (load_data),
            .fetch_count(fcV[g]),
            .abort_count(acV[g])
        );
    end

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            busyM[k]  = 1'b0;
            leftM[k]  = 0;
            validM[k] = 1'b0;
            instM[k]  = 32'h0;
            errM[k]   = 1'b0;
            pendM[k]  = 30'h0;
            fcM[k]    = 16'h0;
            acM[k]    = 16'h0;
        end
    endtask

    task automatic modelComplete(input int k, input logic [29:0] idx);
        busyM[k]  = 1'b0;
        validM[k] = 1'b1;
        if (idx >= 30'(DEPTH)) begin
            instM[k] = 32'h0;
            errM[k]  = 1'b1;
        end else begin
            instM[k] = memM[int'(idx)];
            errM[k]  = 1'b0;
        end
    endtask

    task automatic modelEdge(input logic reqI, input logic [31:0] addrI, input logic abortI,
                             input logic ldI, input logic [31:0] ldAddrI, input logic [31:0] ldDataI);
        for (int k = 0; k < NI; k++) begin
            if (validM[k]) fcM[k] = fcM[k] + 16'd1;
            if (abortI) begin
                if (busyM[k]) acM[k] = acM[k] + 16'd1;
                busyM[k]  = 1'b0;
                validM[k] = 1'b0;
            end else if (busyM[k]) begin
                leftM[k]--;
                if (leftM[k] == 0) modelComplete(k, pendM[k]);
            end else if (reqI) begin
                pendM[k] = addrI[31:2];
                leftM[k] = k;
                if (leftM[k] == 0) begin
                    modelComplete(k, addrI[31:2]);
                end else begin
                    busyM[k]  = 1'b1;
                    validM[k] = 1'b0;
                end
            end else begin
                validM[k] = 1'b0;
            end
        end
        if (ldI) memM[int'(ldAddrI[7:2])] = ldDataI;
    endtask

    task automatic checkOutput();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ready[L%0d]", k + 1), 32'(readyV[k]), 32'(!busyM[k]));
            check($sformatf("valid[L%0d]", k + 1), 32'(validV[k]), 32'(validM[k]));
            check($sformatf("inst[L%0d]", k + 1), instV[k], instM[k]);
            check($sformatf("err[L%0d]", k + 1), 32'(errV[k]), 32'(errM[k]));
`ifdef IFR_STATS_EN
            check($sformatf("fetch_count[L%0d]", k + 1), 32'(fcV[k]), 32'(fcM[k]));
            check($sformatf("abort_count[L%0d]", k + 1), 32'(acV[k]), 32'(acM[k]));
`else
            check($sformatf("fetch_count[L%0d]", k + 1), 32'(fcV[k]), 32'h0);
            check($sformatf("abort_count[L%0d]", k + 1), 32'(acV[k]), 32'h0);
`endif
        end
    endtask

    task automatic applyStimulus(input logic reqI, input logic [31:0] addrI, input logic abortI,
                                 input logic ldI, input logic [31:0] ldAddrI, input logic [31:0] ldDataI);
        req       = reqI;
        addr      = addrI;
        abort     = abortI;
        load_en   = ldI;
        load_addr = ldAddrI;
        load_data = ldDataI;
        @(posedge clk);
        modelEdge(reqI, addrI, abortI, ldI, ldAddrI, ldDataI);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed plan steps followed by a randomized phase, all checked every cycle
    initial begin
        logic [31:0] plan [4];
        logic [31:0] ra;
        logic        rq;
        logic        rab;
        logic        rld;

        plan[0] = 32'hE3A00001;
        plan[1] = 32'hE3A01002;
        plan[2] = 32'hE0802001;
        plan[3] = 32'hEAFFFFFE;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = 1'b0;
        addr      = 32'h0;
        abort     = 1'b0;
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        for (int i = 0; i < DEPTH; i++) memM[i] = 32'h0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] filling program memory");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), plan[i]);

        $display("[TB] single fetch of 0x8");
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        check("plan_wait_l2", 32'(readyV[1]), 32'h0);
        idleCycles(1);
        check("plan_valid_l2", 32'(validV[1]), 32'h1);
        check("plan_inst_l2", instV[1], 32'hE0802001);
        idleCycles(3);

        $display("[TB] back-to-back fetches");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
        idleCycles(4);

        $display("[TB] abort in first wait cycle");
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("plan_abort_ready_l3", 32'(readyV[2]), 32'h1);
        check("plan_abort_valid_l3", 32'(validV[2]), 32'h0);
        idleCycles(4);

        $display("[TB] out-of-range fetches");
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        idleCycles(3);
        applyStimulus(1'b1, 32'h101, 1'b0, 1'b0, 32'h0, 32'h0);
        idleCycles(3);

        $display("[TB] reset during wait");
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
        resetPulse();
        idleCycles(4);

        $display("[TB] load colliding with response read");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h12345678);
        check("plan_old_data_l2", instV[1], 32'hE3A00001);
        idleCycles(3);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idleCycles(1);
        check("plan_new_data_l2", instV[1], 32'h12345678);
        idleCycles(3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            rq  = ($urandom_range(0, 9) < 7);
            rab = ($urandom_range(0, 9) == 0);
            rld = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else ra = (32'($urandom_range(0, 79)) << 2) | ($urandom & 32'h3);
            applyStimulus(rq, ra, rab, rld, $urandom, $urandom);
            if ($urandom_range(0, 99) == 0) resetPulse();
        end
        idleCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
